// File: rtl/snn_pkg.sv
// Shared types and default sizes for the spiking-network output decoder.
package snn_pkg;

   localparam int unsigned DEF_N_CH  = 2;
   localparam int unsigned DEF_CNT_W = 8;
   localparam int unsigned DEF_WIN_W = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } dec_state_e;

   // Width of a channel index; at least one bit even for a single channel.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? int'($clog2(n)) : 1;
   endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Result handshake bus between the rate decoder and its consumer.
interface spike_rate_decoder_if
   import snn_pkg::*;
#(
   parameter int unsigned N_CH  = DEF_N_CH,
   parameter int unsigned CNT_W = DEF_CNT_W
);

   localparam int unsigned IDX_W = idx_width(N_CH);

   logic                  out_valid;
   logic                  out_ready;
   logic [N_CH*CNT_W-1:0] counts;
   logic [IDX_W-1:0]      winner;
   logic                  tie;
   logic                  sat;
   logic                  drop;

   modport master (
      output out_valid, counts, winner, tie, sat, drop,
      input  out_ready
   );

   modport slave (
      input  out_valid, counts, winner, tie, sat, drop,
      output out_ready
   );

endinterface

// File: rtl/spike_sat_counter.sv
// Per-channel saturating spike counter; exposes the value it will hold after this edge.
module spike_sat_counter
   import snn_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count_nxt_c,
   output logic             sat_nxt_c
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] count_q;

   // Saturating increment: holds at the maximum instead of wrapping.
   always_comb begin
      count_nxt_c = count_q;
      if (inc && (count_q != CNT_MAX)) begin
         count_nxt_c = count_q + CNT_W'(1);
      end
      sat_nxt_c = (count_nxt_c == CNT_MAX);
   end

   // Clear overrides the update so the following window starts from zero.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count_q <= '0;
      end else begin
         count_q <= count_nxt_c;
      end
   end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes per channel over a window and reports the most active channel.
module spike_rate_decoder
   import snn_pkg::*;
#(
   parameter int unsigned N_CH  = DEF_N_CH,
   parameter int unsigned CNT_W = DEF_CNT_W,
   parameter int unsigned WIN_W = DEF_WIN_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [N_CH-1:0]      spike_in,
   input  logic [WIN_W-1:0]     win_len,
   spike_rate_decoder_if.master res
);

   localparam int unsigned IDX_W = idx_width(N_CH);

   dec_state_e            state_q;
   dec_state_e            state_d;
   logic [WIN_W-1:0]      win_q;
   logic [WIN_W-1:0]      cyc_q;
   logic                  start_c;
   logic                  last_c;
   logic                  clr_c;
   logic                  hs_c;
   logic                  load_c;

   logic [CNT_W-1:0]      cnt_nxt [N_CH];
   logic [N_CH-1:0]       sat_nxt;
   logic [N_CH*CNT_W-1:0] counts_c;
   logic [CNT_W-1:0]      best_cnt_c;
   logic [IDX_W-1:0]      best_idx_c;
   logic                  tie_c;
   logic                  sat_c;

   logic                  valid_q;
   logic [N_CH*CNT_W-1:0] counts_q;
   logic [IDX_W-1:0]      winner_q;
   logic                  tie_q;
   logic                  sat_q;
   logic                  drop_q;

   assign clr_c  = start_c || last_c;
   assign hs_c   = valid_q && res.out_ready;
   assign load_c = last_c && (!valid_q || res.out_ready);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      spike_sat_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk         (clk),
         .rst         (rst),
         .clr         (clr_c),
         .inc         ((state_q == COUNT) && spike_in[g]),
         .count_nxt_c (cnt_nxt[g]),
         .sat_nxt_c   (sat_nxt[g])
      );
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: en is only looked at in IDLE and on the last sample of a window.
   always_comb begin
      state_d = state_q;
      start_c = 1'b0;
      last_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) begin
               start_c = 1'b1;
               state_d = COUNT;
            end
         end
         COUNT: begin
            if (cyc_q == win_q - WIN_W'(1)) begin
               last_c  = 1'b1;
               start_c = en;
               state_d = en ? COUNT : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Window length latch (zero means one cycle) and sample counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_q <= '0;
         cyc_q <= '0;
      end else if (start_c) begin
         win_q <= (win_len == '0) ? WIN_W'(1) : win_len;
         cyc_q <= '0;
      end else if (state_q == COUNT) begin
         cyc_q <= last_c ? '0 : cyc_q + WIN_W'(1);
      end
   end

   // Winner, tie and saturation over the counts including this cycle's spikes.
   always_comb begin
      counts_c   = '0;
      best_cnt_c = cnt_nxt[0];
      best_idx_c = '0;
      tie_c      = 1'b0;
      sat_c      = |sat_nxt;
      for (int unsigned i = 0; i < N_CH; i++) begin
         counts_c[i*CNT_W +: CNT_W] = cnt_nxt[i];
         if (cnt_nxt[i] > best_cnt_c) begin
            best_cnt_c = cnt_nxt[i];
            best_idx_c = IDX_W'(i);
         end
      end
      for (int unsigned i = 0; i < N_CH; i++) begin
         if ((IDX_W'(i) != best_idx_c) && (cnt_nxt[i] == best_cnt_c)) begin
            tie_c = 1'b1;
         end
      end
   end

   // Result registers: load when free or being consumed, otherwise flag the loss.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         counts_q <= '0;
         winner_q <= '0;
         tie_q    <= 1'b0;
         sat_q    <= 1'b0;
         drop_q   <= 1'b0;
      end else if (load_c) begin
         valid_q  <= 1'b1;
         counts_q <= counts_c;
         winner_q <= best_idx_c;
         tie_q    <= tie_c;
         sat_q    <= sat_c;
         drop_q   <= 1'b0;
      end else begin
         if (hs_c) begin
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
         end
         if (last_c && valid_q && !res.out_ready) begin
            drop_q <= 1'b1;
         end
      end
   end

   assign res.out_valid = valid_q;
   assign res.counts    = counts_q;
   assign res.winner    = winner_q;
   assign res.tie       = tie_q;
   assign res.sat       = sat_q;
   assign res.drop      = drop_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: directed scenarios plus random traffic against a window-level model.
module tb_spike_rate_decoder;

   localparam int unsigned N_CH    = 2;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned WIN_W   = 8;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [N_CH-1:0]  spike_in;
   logic [WIN_W-1:0] win_len;

   int n_assert = 0;
   int n_fail   = 0;

   spike_rate_decoder_if #(.N_CH(N_CH), .CNT_W(CNT_W)) res_if ();

   spike_rate_decoder #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .spike_in (spike_in),
      .win_len  (win_len),
      .res      (res_if)
   );

   always #5 clk = ~clk;

   // Reference model: window bookkeeping with plain integers.
   bit                    m_active;
   bit                    m_valid;
   bit                    m_drop;
   bit                    m_tie;
   bit                    m_sat;
   int unsigned           m_rem;
   int unsigned           m_winner;
   int unsigned           m_acc [N_CH];
   logic [N_CH*CNT_W-1:0] m_counts;

   task automatic model_step();
      bit          done;
      bit          ld;
      bit          hs;
      int unsigned clip [N_CH];
      int unsigned best;
      int unsigned n_best;
      if (rst) begin
         m_active = 0; m_valid = 0; m_drop = 0; m_tie = 0; m_sat = 0;
         m_rem = 0; m_winner = 0; m_counts = '0;
         foreach (m_acc[c]) m_acc[c] = 0;
         return;
      end
      done = 0;
      ld   = 0;
      hs   = m_valid && res_if.out_ready;
      if (m_active) begin
         foreach (m_acc[c]) if (spike_in[c]) m_acc[c]++;
         m_rem--;
         done = (m_rem == 0);
      end
      if (done) begin
         if (!m_valid || res_if.out_ready) begin
            ld   = 1;
            best = 0;
            foreach (m_acc[c]) begin
               clip[c] = (m_acc[c] > CNT_MAX) ? CNT_MAX : m_acc[c];
               if (clip[c] > best) best = clip[c];
            end
            n_best = 0;
            m_sat  = 0;
            foreach (m_acc[c]) begin
               m_counts[c*CNT_W +: CNT_W] = CNT_W'(clip[c]);
               if (clip[c] == best) begin
                  n_best++;
                  if (n_best == 1) m_winner = c;
               end
               if (clip[c] == CNT_MAX) m_sat = 1;
            end
            m_tie   = (n_best > 1);
            m_valid = 1;
            m_drop  = 0;
         end else begin
            m_drop = 1;
         end
         m_active = 0;
      end
      if (!ld && hs) begin
         m_valid = 0;
         m_drop  = 0;
      end
      if (!m_active && en) begin
         m_active = 1;
         m_rem    = (win_len == '0) ? 32'd1 : 32'(win_len);
         foreach (m_acc[c]) m_acc[c] = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: advance the model with the inputs seen at the edge, then compare.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("out_valid", 64'(res_if.out_valid), 64'(m_valid));
      chk("drop", 64'(res_if.drop), 64'(m_drop));
      if (m_valid) begin
         chk("counts", 64'(res_if.counts), 64'(m_counts));
         chk("winner", 64'(res_if.winner), 64'(m_winner));
         chk("tie", 64'(res_if.tie), 64'(m_tie));
         chk("sat", 64'(res_if.sat), 64'(m_sat));
      end
   endtask

   task automatic chk_result(input string tag, input logic [15:0] cnts, input int unsigned win,
                             input bit tie_e, input bit sat_e);
      chk({tag, "_valid"}, 64'(res_if.out_valid), 64'd1);
      chk({tag, "_counts"}, 64'(res_if.counts), 64'(cnts));
      chk({tag, "_winner"}, 64'(res_if.winner), 64'(win));
      chk({tag, "_tie"}, 64'(res_if.tie), 64'(tie_e));
      chk({tag, "_sat"}, 64'(res_if.sat), 64'(sat_e));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 64'(res_if.out_valid), 64'd0);
      chk({tag, "_counts"}, 64'(res_if.counts), 64'd0);
      chk({tag, "_winner"}, 64'(res_if.winner), 64'd0);
      chk({tag, "_tie"}, 64'(res_if.tie), 64'd0);
      chk({tag, "_sat"}, 64'(res_if.sat), 64'd0);
      chk({tag, "_drop"}, 64'(res_if.drop), 64'd0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; spike_in = '0; win_len = '0; res_if.out_ready = 1'b0;
      tick(); tick();
      chk_all_zero("reset");
      rst = 1'b0;

      // Window of 4 on channel 0, consumer always ready.
      win_len = 8'd4; en = 1'b1; spike_in = 2'b01; res_if.out_ready = 1'b1;
      tick();
      repeat (3) tick();
      chk("w4_early_valid", 64'(res_if.out_valid), 64'd0);
      tick();
      chk_result("w4", 16'h0004, 0, 1'b0, 1'b0);
      en = 1'b0;
      tick();
      chk("w4_pulse", 64'(res_if.out_valid), 64'd0);
      repeat (3) tick();
      chk_result("w4_second", 16'h0004, 0, 1'b0, 1'b0);
      spike_in = '0;
      repeat (2) tick();

      // Zero length behaves as a single-cycle window.
      win_len = 8'd0; en = 1'b1; spike_in = 2'b10;
      tick();
      en = 1'b0;
      tick();
      chk_result("w0", 16'h0100, 1, 1'b0, 1'b0);
      spike_in = '0;
      tick();

      // Equal counts resolve to the lowest index with tie set.
      win_len = 8'd3; en = 1'b1; spike_in = 2'b11;
      tick();
      en = 1'b0;
      repeat (3) tick();
      chk_result("tie", 16'h0303, 0, 1'b1, 1'b0);
      spike_in = '0;
      tick();

      // Longest window reaching the counter maximum.
      win_len = 8'd255; en = 1'b1; spike_in = 2'b01;
      tick();
      en = 1'b0;
      repeat (255) tick();
      chk_result("satw", 16'h00ff, 0, 1'b0, 1'b1);
      repeat (45) tick();
      spike_in = '0;
      tick();

      // Stalled consumer across three windows, then release.
      res_if.out_ready = 1'b0; win_len = 8'd2; en = 1'b1; spike_in = 2'b01;
      tick();
      repeat (2) tick();
      chk_result("hold1", 16'h0002, 0, 1'b0, 1'b0);
      chk("hold1_drop", 64'(res_if.drop), 64'd0);
      spike_in = 2'b10;
      repeat (2) tick();
      chk_result("hold2", 16'h0002, 0, 1'b0, 1'b0);
      chk("hold2_drop", 64'(res_if.drop), 64'd1);
      spike_in = 2'b11;
      repeat (2) tick();
      chk_result("hold3", 16'h0002, 0, 1'b0, 1'b0);
      chk("hold3_drop", 64'(res_if.drop), 64'd1);
      en = 1'b0; res_if.out_ready = 1'b1; spike_in = 2'b11;
      tick();
      chk("release_valid", 64'(res_if.out_valid), 64'd0);
      chk("release_drop", 64'(res_if.drop), 64'd0);
      spike_in = 2'b10;
      tick();
      chk_result("fresh", 16'h0201, 1, 1'b0, 1'b0);
      chk("fresh_drop", 64'(res_if.drop), 64'd0);

      // Reset in the middle of a window while a result is held.
      res_if.out_ready = 1'b0; win_len = 8'd5; en = 1'b1; spike_in = 2'b11;
      tick();
      repeat (2) tick();
      rst = 1'b1;
      tick();
      chk_all_zero("midrst");
      rst = 1'b0; win_len = 8'd2; spike_in = 2'b01; res_if.out_ready = 1'b1;
      tick();
      en = 1'b0;
      repeat (2) tick();
      chk_result("postrst", 16'h0002, 0, 1'b0, 1'b0);
      tick();

      // Random traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         rst              = ($urandom_range(0, 399) == 0);
         en               = ($urandom_range(0, 7) != 0);
         spike_in         = N_CH'($urandom);
         win_len          = WIN_W'($urandom_range(0, 6));
         res_if.out_ready = ($urandom_range(0, 2) != 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
